// File: rtl/trap_sequencer_pkg.sv
// rtl/trap_sequencer_pkg.sv - shared types, mstatus bit positions and CSR constants for the trap sequencer
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_TVAL,
    ST_W_STATUS,
    ST_REDIRECT
  } seq_state_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } priv_e;

  typedef enum logic [1:0] {
    EV_EXC  = 2'd0,
    EV_MRET = 2'd1,
    EV_SRET = 2'd2,
    EV_IRQ  = 2'd3
  } ev_kind_e;

  localparam int MS_SIE    = 1;
  localparam int MS_MIE    = 3;
  localparam int MS_SPIE   = 5;
  localparam int MS_MPIE   = 7;
  localparam int MS_SPP    = 8;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  localparam logic [3:0] IRQ_SSI = 4'd1;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_STI = 4'd5;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_SEI = 4'd9;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // Nibble 0 is the lowest priority source; later nibbles override earlier ones.
  localparam logic [23:0] IRQ_PRIO_LOW_TO_HIGH =
    {IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI};

endpackage

// File: rtl/trap_sequencer_irq_select.sv
// rtl/trap_sequencer_irq_select.sv - picks the highest-priority takeable interrupt and its target level
module trap_sequencer_irq_select
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mideleg,
  input  logic [1:0]      priv,
  input  logic            m_ie,
  input  logic            s_ie,
  output logic            take,
  output logic [3:0]      code,
  output logic            to_s
);

  logic       m_en;
  logic       s_en;
  logic [3:0] cand;
  logic       unused_bits;

  assign unused_bits = ^{mip, mie, mideleg};

  always_comb begin
    take = 1'b0;
    code = '0;
    to_s = 1'b0;
    cand = '0;
    m_en = (priv != PRIV_M) || m_ie;
    // S-level interrupts are never taken while running in M.
    s_en = (priv == PRIV_U) || ((priv == PRIV_S) && s_ie);
    for (int k = 0; k < 6; k++) begin
      cand = IRQ_PRIO_LOW_TO_HIGH[4*k +: 4];
      if (mip[cand] && mie[cand] && (mideleg[cand] ? s_en : m_en)) begin
        take = 1'b1;
        code = cand;
        to_s = mideleg[cand];
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap entry / xRET sequencer: CSR write sequence, fetch redirect, privilege mode
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ev_valid,
  output logic            ev_ready,
  input  logic [1:0]      ev_kind,
  input  logic [3:0]      ev_cause,
  input  logic [XLEN-1:0] ev_tval,
  input  logic [XLEN-1:0] ev_pc,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mip,
  input  logic [XLEN-1:0] csr_mie,
  input  logic [XLEN-1:0] csr_medeleg,
  input  logic [XLEN-1:0] csr_mideleg,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_stvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic [XLEN-1:0] csr_sepc,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv_mode,
  output logic            busy
);

  seq_state_e      state_q, state_d;
  logic [1:0]      priv_q, priv_d;
  logic [1:0]      kind_q, kind_d;
  logic            irq_q, irq_d;
  logic            to_s_q, to_s_d;
  logic [3:0]      code_q, code_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] rpc_q, rpc_d;

  logic            irq_take;
  logic            irq_to_s;
  logic [3:0]      irq_code;
  logic            exc_to_s;
  logic [XLEN-1:0] status_nxt;
  logic [XLEN-1:0] tvec;

  trap_sequencer_irq_select #(.XLEN(XLEN)) u_irq_select (
    .mip     (csr_mip),
    .mie     (csr_mie),
    .mideleg (csr_mideleg),
    .priv    (priv_q),
    .m_ie    (csr_mstatus[MS_MIE]),
    .s_ie    (csr_mstatus[MS_SIE]),
    .take    (irq_take),
    .code    (irq_code),
    .to_s    (irq_to_s)
  );

  always_comb begin
    state_d        = state_q;
    priv_d         = priv_q;
    kind_d         = kind_q;
    irq_d          = irq_q;
    to_s_d         = to_s_q;
    code_d         = code_q;
    epc_d          = epc_q;
    tval_d         = tval_q;
    rpc_d          = rpc_q;
    ev_ready       = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    status_nxt     = csr_mstatus;
    tvec           = '0;
    exc_to_s       = csr_medeleg[ev_cause] && (priv_q != PRIV_M);

    case (state_q)
      ST_IDLE: begin
        if (ev_valid) begin
          ev_ready = 1'b1;
          kind_d   = ev_kind;
          epc_d    = ev_pc;
          case (ev_kind)
            EV_EXC: begin
              irq_d   = 1'b0;
              code_d  = ev_cause;
              to_s_d  = exc_to_s;
              tval_d  = ev_tval;
              state_d = ST_W_EPC;
            end
            EV_IRQ: begin
              // Nothing takeable: the boundary is acknowledged as a no-op.
              if (irq_take) begin
                irq_d   = 1'b1;
                code_d  = irq_code;
                to_s_d  = irq_to_s;
                tval_d  = '0;
                state_d = ST_W_EPC;
              end
            end
            default: state_d = ST_W_STATUS;
          endcase
        end
      end
      ST_W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = to_s_q ? CSR_SEPC : CSR_MEPC;
        csr_wdata = epc_q;
        state_d   = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = to_s_q ? CSR_SCAUSE : CSR_MCAUSE;
        csr_wdata = {irq_q, {(XLEN-5){1'b0}}, code_q};
        state_d   = ST_W_TVAL;
      end
      ST_W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = to_s_q ? CSR_STVAL : CSR_MTVAL;
        csr_wdata = tval_q;
        state_d   = ST_W_STATUS;
      end
      ST_W_STATUS: begin
        case (kind_q)
          EV_MRET: begin
            status_nxt[MS_MIE]               = csr_mstatus[MS_MPIE];
            status_nxt[MS_MPIE]              = 1'b1;
            status_nxt[MS_MPP_HI:MS_MPP_LO]  = PRIV_U;
            priv_d                           = csr_mstatus[MS_MPP_HI:MS_MPP_LO];
            rpc_d                            = csr_mepc;
          end
          EV_SRET: begin
            status_nxt[MS_SIE]  = csr_mstatus[MS_SPIE];
            status_nxt[MS_SPIE] = 1'b1;
            status_nxt[MS_SPP]  = 1'b0;
            priv_d              = {1'b0, csr_mstatus[MS_SPP]};
            rpc_d               = csr_sepc;
          end
          default: begin
            if (to_s_q) begin
              status_nxt[MS_SPIE] = csr_mstatus[MS_SIE];
              status_nxt[MS_SIE]  = 1'b0;
              status_nxt[MS_SPP]  = priv_q[0];
              priv_d              = PRIV_S;
              tvec                = csr_stvec;
            end else begin
              status_nxt[MS_MPIE]             = csr_mstatus[MS_MIE];
              status_nxt[MS_MIE]              = 1'b0;
              status_nxt[MS_MPP_HI:MS_MPP_LO] = priv_q;
              priv_d                          = PRIV_M;
              tvec                            = csr_mtvec;
            end
            rpc_d = {tvec[XLEN-1:2], 2'b00} +
                    (((tvec[1:0] == 2'b01) && irq_q) ? XLEN'({code_q, 2'b00}) : '0);
          end
        endcase
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = status_nxt;
        state_d   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      priv_q  <= PRIV_M;
      kind_q  <= '0;
      irq_q   <= 1'b0;
      to_s_q  <= 1'b0;
      code_q  <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      priv_q  <= priv_d;
      kind_q  <= kind_d;
      irq_q   <= irq_d;
      to_s_q  <= to_s_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      rpc_q   <= rpc_d;
    end
  end

  assign priv_mode   = priv_q;
  assign redirect_pc = rpc_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed-vector bench for trap_sequencer
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_kind;
  logic [3:0]  ev_cause;
  logic [31:0] ev_tval, ev_pc;
  logic [31:0] csr_mstatus, csr_mip, csr_mie, csr_medeleg, csr_mideleg;
  logic [31:0] csr_mtvec, csr_stvec, csr_mepc, csr_sepc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic [1:0]  priv_mode;
  logic        busy;

  int          vecs = 0;
  int          errs = 0;

  logic [11:0] wa [8];
  logic [31:0] wd [8];
  int          nw;
  int          wr_cycles;
  logic        got_ready;
  logic        got_redir;
  logic [31:0] redir_pc;

  trap_sequencer #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_kind        (ev_kind),
    .ev_cause       (ev_cause),
    .ev_tval        (ev_tval),
    .ev_pc          (ev_pc),
    .csr_mstatus    (csr_mstatus),
    .csr_mip        (csr_mip),
    .csr_mie        (csr_mie),
    .csr_medeleg    (csr_medeleg),
    .csr_mideleg    (csr_mideleg),
    .csr_mtvec      (csr_mtvec),
    .csr_stvec      (csr_stvec),
    .csr_mepc       (csr_mepc),
    .csr_sepc       (csr_sepc),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .priv_mode      (priv_mode),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Presents one event, then records CSR writes until redirect_valid rises (bounded).
  task automatic send_event(input logic [1:0] kind, input logic [3:0] cause,
                            input logic [31:0] tval, input logic [31:0] pc);
    got_ready = 1'b0;
    got_redir = 1'b0;
    nw        = 0;
    wr_cycles = 0;
    redir_pc  = '0;
    @(posedge clk); #1;
    ev_valid = 1'b1; ev_kind = kind; ev_cause = cause; ev_tval = tval; ev_pc = pc;
    #1;
    got_ready = ev_ready;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (redirect_valid) begin
        got_redir = 1'b1;
        redir_pc  = redirect_pc;
        break;
      end
      if (csr_we && nw < 8) begin
        wa[nw] = csr_waddr;
        wd[nw] = csr_wdata;
        nw++;
      end
      wr_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic accept_redirect();
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vecs++; if (priv_mode !== 2'd3) begin errs++; $display("FAIL reset_priv got=%0d exp=3", priv_mode); end
    vecs++; if ({csr_we, redirect_valid, ev_ready, busy} !== 4'b0) begin errs++; $display("FAIL reset_strobes got=%b exp=0000", {csr_we, redirect_valid, ev_ready, busy}); end
    vecs++; if ({csr_waddr, csr_wdata, redirect_pc} !== 76'h0) begin errs++; $display("FAIL reset_data got=%h/%h/%h exp=0", csr_waddr, csr_wdata, redirect_pc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ecall_m();
    csr_mstatus = 32'h0004_0008;
    csr_mtvec   = 32'h100;
    send_event(2'd0, 4'd11, 32'h0, 32'h400);
    vecs++; if (got_ready !== 1'b1) begin errs++; $display("FAIL ecall_m_ready got=%b exp=1", got_ready); end
    vecs++; if (nw !== 4 || wr_cycles !== 4) begin errs++; $display("FAIL ecall_m_count got=%0d/%0d exp=4/4", nw, wr_cycles); end
    vecs++; if (wa[0] !== 12'h341 || wd[0] !== 32'h400) begin errs++; $display("FAIL ecall_m_epc got=%h:%h exp=341:400", wa[0], wd[0]); end
    vecs++; if (wa[1] !== 12'h342 || wd[1] !== 32'd11) begin errs++; $display("FAIL ecall_m_cause got=%h:%h exp=342:b", wa[1], wd[1]); end
    vecs++; if (wa[2] !== 12'h343 || wd[2] !== 32'h0) begin errs++; $display("FAIL ecall_m_tval got=%h:%h exp=343:0", wa[2], wd[2]); end
    vecs++; if (wa[3] !== 12'h300 || wd[3] !== 32'h0004_1880) begin errs++; $display("FAIL ecall_m_status got=%h:%h exp=300:41880", wa[3], wd[3]); end
    vecs++; if (got_redir !== 1'b1 || redir_pc !== 32'h100 || priv_mode !== 2'd3) begin errs++; $display("FAIL ecall_m_redirect got=%b/%h/%0d exp=1/100/3", got_redir, redir_pc, priv_mode); end
    accept_redirect();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL ecall_m_idle got=%b exp=0", busy); end
  endtask

  task automatic test_irq_masked();
    csr_mstatus = 32'h0;
    csr_mip     = 32'h80;
    csr_mie     = 32'h80;
    csr_mideleg = 32'h0;
    send_event(2'd3, 4'd0, 32'h0, 32'h440);
    vecs++; if (got_ready !== 1'b1) begin errs++; $display("FAIL irq_masked_ready got=%b exp=1", got_ready); end
    vecs++; if (nw !== 0 || got_redir !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL irq_masked_noop got=%0d/%b/%b exp=0/0/0", nw, got_redir, busy); end
    vecs++; if (priv_mode !== 2'd3) begin errs++; $display("FAIL irq_masked_priv got=%0d exp=3", priv_mode); end
    csr_mip = 32'h0;
    csr_mie = 32'h0;
  endtask

  task automatic test_mret();
    csr_mstatus = 32'h80;
    csr_mepc    = 32'h80;
    send_event(2'd1, 4'd0, 32'h0, 32'h444);
    vecs++; if (nw !== 1 || wr_cycles !== 1) begin errs++; $display("FAIL mret_count got=%0d/%0d exp=1/1", nw, wr_cycles); end
    vecs++; if (wa[0] !== 12'h300 || wd[0] !== 32'h88) begin errs++; $display("FAIL mret_status got=%h:%h exp=300:88", wa[0], wd[0]); end
    vecs++; if (got_redir !== 1'b1 || redir_pc !== 32'h80 || priv_mode !== 2'd0) begin errs++; $display("FAIL mret_redirect got=%b/%h/%0d exp=1/80/0", got_redir, redir_pc, priv_mode); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      vecs++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin errs++; $display("FAIL mret_hold%0d got=%b/%h exp=1/80", c, redirect_valid, redirect_pc); end
    end
    accept_redirect();
    vecs++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin errs++; $display("FAIL mret_idle got=%b/%b exp=0/0", busy, redirect_valid); end
  endtask

  task automatic test_deleg_u();
    csr_mstatus = 32'h0A;
    csr_medeleg = 32'h100;
    csr_stvec   = 32'h200;
    send_event(2'd0, 4'd8, 32'h0, 32'h84);
    vecs++; if (wa[0] !== 12'h141 || wd[0] !== 32'h84) begin errs++; $display("FAIL deleg_sepc got=%h:%h exp=141:84", wa[0], wd[0]); end
    vecs++; if (wa[1] !== 12'h142 || wd[1] !== 32'd8) begin errs++; $display("FAIL deleg_scause got=%h:%h exp=142:8", wa[1], wd[1]); end
    vecs++; if (wa[2] !== 12'h143 || wd[2] !== 32'h0) begin errs++; $display("FAIL deleg_stval got=%h:%h exp=143:0", wa[2], wd[2]); end
    vecs++; if (wa[3] !== 12'h300 || wd[3] !== 32'h28) begin errs++; $display("FAIL deleg_status got=%h:%h exp=300:28", wa[3], wd[3]); end
    vecs++; if (got_redir !== 1'b1 || redir_pc !== 32'h200 || priv_mode !== 2'd1) begin errs++; $display("FAIL deleg_redirect got=%b/%h/%0d exp=1/200/1", got_redir, redir_pc, priv_mode); end
    accept_redirect();
    csr_medeleg = 32'h0;
  endtask

  task automatic test_irq_s_to_m();
    csr_mstatus = 32'h0;
    csr_mip     = 32'h880;
    csr_mie     = 32'h880;
    csr_mideleg = 32'h0;
    csr_mtvec   = 32'h301;
    send_event(2'd3, 4'd0, 32'hFFFF, 32'h204);
    vecs++; if (nw !== 4 || wr_cycles !== 4) begin errs++; $display("FAIL irq_count got=%0d/%0d exp=4/4", nw, wr_cycles); end
    vecs++; if (wa[0] !== 12'h341 || wd[0] !== 32'h204) begin errs++; $display("FAIL irq_mepc got=%h:%h exp=341:204", wa[0], wd[0]); end
    vecs++; if (wa[1] !== 12'h342 || wd[1] !== 32'h8000_000B) begin errs++; $display("FAIL irq_mcause got=%h:%h exp=342:8000000b", wa[1], wd[1]); end
    vecs++; if (wa[2] !== 12'h343 || wd[2] !== 32'h0) begin errs++; $display("FAIL irq_mtval got=%h:%h exp=343:0", wa[2], wd[2]); end
    vecs++; if (wa[3] !== 12'h300 || wd[3] !== 32'h800) begin errs++; $display("FAIL irq_status got=%h:%h exp=300:800", wa[3], wd[3]); end
    vecs++; if (got_redir !== 1'b1 || redir_pc !== 32'h32C || priv_mode !== 2'd3) begin errs++; $display("FAIL irq_redirect got=%b/%h/%0d exp=1/32c/3", got_redir, redir_pc, priv_mode); end
    accept_redirect();
    csr_mip   = 32'h0;
    csr_mie   = 32'h0;
    csr_mtvec = 32'h100;
  endtask

  task automatic test_mret_to_s();
    csr_mstatus = 32'h880;
    csr_mepc    = 32'h90;
    send_event(2'd1, 4'd0, 32'h0, 32'h208);
    vecs++; if (wd[0] !== 32'h88 || nw !== 1) begin errs++; $display("FAIL mret_s_status got=%h/%0d exp=88/1", wd[0], nw); end
    vecs++; if (redir_pc !== 32'h90 || priv_mode !== 2'd1) begin errs++; $display("FAIL mret_s_redirect got=%h/%0d exp=90/1", redir_pc, priv_mode); end
    accept_redirect();
  endtask

  task automatic test_reset_mid();
    csr_mstatus = 32'h0;
    @(posedge clk); #1;
    ev_valid = 1'b1; ev_kind = 2'd0; ev_cause = 4'd9; ev_tval = 32'h0; ev_pc = 32'h500;
    @(posedge clk); #2;
    vecs++; if (busy !== 1'b1 || ev_ready !== 1'b0) begin errs++; $display("FAIL busy_ignore got=%b/%b exp=1/0", busy, ev_ready); end
    vecs++; if (csr_we !== 1'b1 || csr_waddr !== 12'h341 || csr_wdata !== 32'h500) begin errs++; $display("FAIL mid_epc got=%b/%h/%h exp=1/341/500", csr_we, csr_waddr, csr_wdata); end
    @(posedge clk); #2;
    vecs++; if (csr_waddr !== 12'h342 || csr_wdata !== 32'd9 || priv_mode !== 2'd1) begin errs++; $display("FAIL mid_cause got=%h/%h/%0d exp=342/9/1", csr_waddr, csr_wdata, priv_mode); end
    ev_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    vecs++; if (csr_we !== 1'b0 || busy !== 1'b0 || priv_mode !== 2'd3) begin errs++; $display("FAIL mid_reset got=%b/%b/%0d exp=0/0/3", csr_we, busy, priv_mode); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      vecs++; if (csr_we !== 1'b0 || redirect_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL mid_after%0d got=%b/%b/%b exp=0/0/0", c, csr_we, redirect_valid, busy); end
    end
  endtask

  initial begin
    ev_valid = 1'b0; ev_kind = '0; ev_cause = '0; ev_tval = '0; ev_pc = '0;
    csr_mstatus = '0; csr_mip = '0; csr_mie = '0; csr_medeleg = '0; csr_mideleg = '0;
    csr_mtvec = '0; csr_stvec = '0; csr_mepc = '0; csr_sepc = '0;
    redirect_ready = 1'b0;
    test_reset();
    test_ecall_m();
    test_irq_masked();
    test_mret();
    test_deleg_u();
    test_irq_s_to_m();
    test_mret_to_s();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
